// File: rtl/colorclk_pkg.sv
// Shared definitions for the colour-clock controller: configuration encoding,
// the four phase-accumulator increments and the controller state enumeration.
package colorclk_pkg;

  // Width of the phase-accumulator increment and of the shared cycle counter.
  localparam int INC_W = 29;
  localparam int CNT_W = 16;

  // Configuration word layout is {altern, mode}.
  //   mode   : 0 = PAL,     1 = NTSC
  //   altern : 0 = 140 MHz, 1 = 170 MHz
  typedef logic [1:0] cfg_t;

  localparam cfg_t CFG_PAL_140  = 2'b00;
  localparam cfg_t CFG_NTSC_140 = 2'b01;
  localparam cfg_t CFG_PAL_170  = 2'b10;
  localparam cfg_t CFG_NTSC_170 = 2'b11;

  // Increments that make the accumulator produce colorclk4x for each plan.
  localparam logic [INC_W-1:0] INC_PAL_140  = 29'd68008027;
  localparam logic [INC_W-1:0] INC_NTSC_140 = 29'd54907245;
  localparam logic [INC_W-1:0] INC_PAL_170  = 29'd56006610;
  localparam logic [INC_W-1:0] INC_NTSC_170 = 29'd45217732;

  // Controller states. LOAD is the reset state so that the first clock after
  // reset release programs the accumulator from a known configuration.
  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_RUN      = 3'd2,
    ST_DEBOUNCE = 3'd3,
    ST_GATE     = 3'd4
  } state_t;

  // Map a configuration word to its accumulator increment.
  function automatic logic [INC_W-1:0] inc_lookup(input cfg_t cfg);
    logic [INC_W-1:0] inc;
    case (cfg)
      CFG_PAL_140:  inc = INC_PAL_140;
      CFG_NTSC_140: inc = INC_NTSC_140;
      CFG_PAL_170:  inc = INC_PAL_170;
      CFG_NTSC_170: inc = INC_NTSC_170;
      default:      inc = INC_PAL_140;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a single level signal crossing into clk.
module cdc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous level, then re-register it to resolve metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/colorclk_ctrl.sv
// Colour-clock configuration controller.
// Watches the (asynchronous) PAL/NTSC and 140/170 MHz requests, debounces a
// change, gates the colorclk4x output, loads the matching accumulator
// increment with an accumulator clear, waits for the output to settle and
// then re-enables it. The increment only ever changes while the output is
// gated off.
module colorclk_ctrl
  import colorclk_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int GATE_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_req,
  input  logic             altern_req,
  output logic [INC_W-1:0] phase_inc,
  output logic             acc_clr,
  output logic             out_en,
  output logic             locked,
  output logic             busy,
  output logic [1:0]       cfg_applied
);

  // The shared counter is 16 bits; every duration must fit and be non-zero.
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 ||
      GATE_CYCLES   < 1 || GATE_CYCLES   > 65535 ||
      SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_bad_params
    $error("colorclk_ctrl: STABLE/GATE/SETTLE_CYCLES must be within 1..65535");
  end

  // Terminal counts: a phase lasting N cycles ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Request synchronization
  // ---------------------------------------------------------------------------
  logic mode_sync;
  logic altern_sync;
  cfg_t sync_cfg;

  cdc_sync2 u_sync_mode (
    .clk (clk),
    .rst (rst),
    .d   (mode_req),
    .q   (mode_sync)
  );

  cdc_sync2 u_sync_altern (
    .clk (clk),
    .rst (rst),
    .d   (altern_req),
    .q   (altern_sync)
  );

  assign sync_cfg = {altern_sync, mode_sync};

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  cfg_t             candidate;
  cfg_t             candidate_next;
  logic [INC_W-1:0] inc_next;
  cfg_t             cfg_next;
  logic             acc_clr_next;
  logic             out_en_next;
  logic             locked_next;
  logic             busy_next;

  // Next-state, counter, candidate and load decisions for the controller.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    candidate_next = candidate;
    inc_next       = phase_inc;
    cfg_next       = cfg_applied;

    case (state)
      ST_LOAD: begin
        // Single cycle: program the accumulator from the debounced candidate.
        inc_next   = inc_lookup(candidate);
        cfg_next   = candidate;
        cnt_next   = {CNT_W{1'b0}};
        state_next = ST_SETTLE;
      end

      ST_SETTLE: begin
        // Request changes are deliberately not looked at here; RUN picks
        // them up again once the new configuration is live.
        if (cnt == SETTLE_LAST) begin
          cnt_next   = {CNT_W{1'b0}};
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end

      ST_RUN: begin
        if (sync_cfg != cfg_applied) begin
          candidate_next = sync_cfg;
          cnt_next       = {CNT_W{1'b0}};
          state_next     = ST_DEBOUNCE;
        end else begin
          cnt_next = {CNT_W{1'b0}};
        end
      end

      ST_DEBOUNCE: begin
        if (sync_cfg == cfg_applied) begin
          // Request went back to what is already loaded: nothing to do.
          cnt_next   = {CNT_W{1'b0}};
          state_next = ST_RUN;
        end else if (sync_cfg != candidate) begin
          // Request moved again: track the newest value and restart timing.
          candidate_next = sync_cfg;
          cnt_next       = {CNT_W{1'b0}};
        end else if (cnt == STABLE_LAST) begin
          cnt_next   = {CNT_W{1'b0}};
          state_next = ST_GATE;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end

      ST_GATE: begin
        if (cnt == GATE_LAST) begin
          cnt_next   = {CNT_W{1'b0}};
          state_next = ST_LOAD;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end

      default: begin
        // Unreachable encodings recover through a fresh load of the candidate.
        cnt_next   = {CNT_W{1'b0}};
        state_next = ST_LOAD;
      end
    endcase
  end

  // Output decode: the output registers reflect the state being executed,
  // so acc_clr coincides with the increment update.
  always_comb begin
    acc_clr_next = 1'b0;
    out_en_next  = 1'b0;
    locked_next  = 1'b0;
    busy_next    = (state_next != ST_RUN);

    case (state)
      ST_LOAD: begin
        acc_clr_next = 1'b1;
      end
      ST_RUN, ST_DEBOUNCE: begin
        // Debouncing keeps the current configuration live and locked.
        out_en_next = 1'b1;
        locked_next = 1'b1;
      end
      ST_SETTLE, ST_GATE: begin
        out_en_next = 1'b0;
        locked_next = 1'b0;
      end
      default: begin
        acc_clr_next = 1'b0;
      end
    endcase
  end

  // Controller state, shared counter and debounce candidate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      cnt       <= {CNT_W{1'b0}};
      candidate <= CFG_PAL_140;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      candidate <= candidate_next;
    end
  end

  // Registered outputs; reset aborts any sequence back to the PAL/140 load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_inc   <= INC_PAL_140;
      cfg_applied <= CFG_PAL_140;
      acc_clr     <= 1'b0;
      out_en      <= 1'b0;
      locked      <= 1'b0;
      busy        <= 1'b1;
    end else begin
      phase_inc   <= inc_next;
      cfg_applied <= cfg_next;
      acc_clr     <= acc_clr_next;
      out_en      <= out_en_next;
      locked      <= locked_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_colorclk_ctrl.sv
// Self-checking bench for colorclk_ctrl (STABLE=4, GATE=2, SETTLE=3).
// A behavioural model predicts acc_clr pulses (with increment/config), locked
// rise and fall instants; a monitor pops and compares when the DUT shows them.
module tb_colorclk_ctrl;

  localparam int STABLE = 4;
  localparam int GATE   = 2;
  localparam int SETTLE = 3;
  localparam int NEVER  = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode_req = 1'b0;
  logic        altern_req = 1'b0;
  logic [28:0] phase_inc;
  logic        acc_clr;
  logic        out_en;
  logic        locked;
  logic        busy;
  logic [1:0]  cfg_applied;

  colorclk_ctrl #(
    .STABLE_CYCLES (STABLE),
    .GATE_CYCLES   (GATE),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_req    (mode_req),
    .altern_req  (altern_req),
    .phase_inc   (phase_inc),
    .acc_clr     (acc_clr),
    .out_en      (out_en),
    .locked      (locked),
    .busy        (busy),
    .cfg_applied (cfg_applied)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  typedef struct {
    int          cyc;
    logic [28:0] inc;
    logic [1:0]  cfg;
  } clr_ev_t;

  clr_ev_t clr_q[$];
  int      lock_q[$];
  int      drop_q[$];

  // Reference increments, indexed {altern, mode}.
  function automatic logic [28:0] ref_inc(input logic [1:0] c);
    case (c)
      2'b00:   return 29'd68008027;
      2'b01:   return 29'd54907245;
      2'b10:   return 29'd56006610;
      default: return 29'd45217732;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edge_n);
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 = running, 1 = waiting for a stable new request, 2 = reconfiguring.
  logic [1:0] d1, d2, m_applied, m_pending;
  int         m_phase, m_match, m_load, m_run;

  task automatic model_reset();
    d1 = 2'b00; d2 = 2'b00;
    m_applied = 2'b00; m_pending = 2'b00;
    m_phase = 2; m_match = 0; m_load = 1; m_run = NEVER;
    clr_q.delete(); lock_q.delete(); drop_q.delete();
  endtask

  // Controller decision at clock edge n; requests reach it two edges late.
  task automatic model_edge(input int n);
    logic [1:0] seen;
    clr_ev_t    ev;
    seen = d2;
    d2 = d1;
    d1 = {altern_req, mode_req};
    if (m_phase == 2 && n == m_run) m_phase = 0;
    case (m_phase)
      0: begin
        if (seen != m_applied) begin
          m_pending = seen; m_match = 0; m_phase = 1;
        end
      end
      1: begin
        if (seen == m_applied) m_phase = 0;
        else if (seen != m_pending) begin
          m_pending = seen; m_match = 0;
        end else begin
          m_match++;
          if (m_match == STABLE) begin
            m_phase = 2;
            drop_q.push_back(n + 1);
            m_load = n + GATE + 1;
            m_run = NEVER;
          end
        end
      end
      default: begin
        if (n == m_load) begin
          m_applied = m_pending;
          ev.cyc = n; ev.inc = ref_inc(m_pending); ev.cfg = m_pending;
          clr_q.push_back(ev);
          m_run = n + SETTLE + 1;
          lock_q.push_back(m_run);
        end
      end
    endcase
  endtask

  // One clock: model the edge, then drive the next request value.
  task automatic step(input logic [1:0] cfg);
    @(posedge clk);
    edge_n++;
    model_edge(edge_n);
    #1;
    altern_req = cfg[1];
    mode_req   = cfg[0];
  endtask

  task automatic check_reset_values();
    check("rst_acc_clr", 32'(acc_clr), 32'd0);
    check("rst_out_en", 32'(out_en), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_phase_inc", 32'(phase_inc), 32'd68008027);
    check("rst_cfg_applied", 32'(cfg_applied), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    model_reset();
    edge_n = 0;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        prev_locked;
    logic [28:0] prev_inc;
    clr_ev_t     ev;
    int          c;
    prev_locked = 1'b0;
    prev_inc = 29'd68008027;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_locked = 1'b0;
        prev_inc = 29'd68008027;
      end else begin
        if (acc_clr) begin
          if (clr_q.size() == 0) begin
            n_checks++;
            $display("FAIL acc_clr_unexpected: pulse at cycle %0d, none expected", edge_n);
          end else begin
            ev = clr_q.pop_front();
            check("acc_clr_cycle", 32'(edge_n), 32'(ev.cyc));
            check("phase_inc", 32'(phase_inc), 32'(ev.inc));
            check("cfg_applied", 32'(cfg_applied), 32'(ev.cfg));
            check("out_en_at_load", 32'(out_en), 32'd0);
          end
        end else if (phase_inc != prev_inc) begin
          check("phase_inc_only_in_load", 32'(phase_inc), 32'(prev_inc));
        end
        if (locked && !prev_locked) begin
          if (lock_q.size() == 0) begin
            n_checks++;
            $display("FAIL locked_rise_unexpected: at cycle %0d, none expected", edge_n);
          end else begin
            c = lock_q.pop_front();
            check("locked_rise_cycle", 32'(edge_n), 32'(c));
          end
        end
        if (!locked && prev_locked) begin
          if (drop_q.size() == 0) begin
            n_checks++;
            $display("FAIL locked_fall_unexpected: at cycle %0d, none expected", edge_n);
          end else begin
            c = drop_q.pop_front();
            check("locked_fall_cycle", 32'(edge_n), 32'(c));
          end
        end
        check("out_en_eq_locked", 32'(out_en), 32'(locked));
        prev_locked = locked;
        prev_inc = phase_inc;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Directed segments: power-up, NTSC switch, short glitch, change during
  // settle, and a burst of request changes inside one debounce window.
  logic [1:0] dir_cfg  [0:9] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
                                 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
  int         dir_hold [0:9] = '{10, 20, 3, 20, 11, 25, 25, 2, 2, 25};

  initial begin
    logic [1:0] cfg;
    logic       in_gate;
    model_reset();
    #1 rst = 1'b1;
    #10;
    check_reset_values();
    release_reset();

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < dir_hold[i]; k++) step(dir_cfg[i]);
    end

    for (int i = 0; i < 40; i++) begin
      cfg = 2'($urandom_range(0, 3));
      for (int k = 0; k < int'($urandom_range(1, 14)); k++) step(cfg);
    end

    // Abort a reconfiguration while the output is gated.
    cfg = ~m_applied;
    in_gate = 1'b0;
    for (int k = 0; k < 60 && !in_gate; k++) begin
      step(cfg);
      in_gate = (m_phase == 2) && (edge_n < m_load) && (m_run == NEVER);
    end
    if (!in_gate) begin
      n_checks++;
      $display("FAIL gate_wait_timeout: gate phase not reached within 60 cycles");
    end
    #2 rst = 1'b1;
    #1;
    check_reset_values();
    {altern_req, mode_req} = 2'b00;
    release_reset();
    for (int k = 0; k < 12; k++) step(2'b00);

    for (int k = 0; k < 30; k++) step(2'b01);
    @(negedge clk);
    #1;
    check("clr_events_drained", 32'(clr_q.size()), 32'd0);
    check("lock_events_drained", 32'(lock_q.size()), 32'd0);
    check("drop_events_drained", 32'(drop_q.size()), 32'd0);
    check("final_cfg_applied", 32'(cfg_applied), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/colorclk_ctrl.md
COLORCLK_CTRL -- requirements
Module: colorclk_ctrl

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024, meaning consecutive cycles a new mode/altern request must hold before it is applied.
REQ-002 SHALL have parameter GATE_CYCLES, default 16, meaning cycles out_en is held low before a new increment is loaded.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256, meaning cycles after load before out_en and locked reassert.
REQ-004 SHALL have port clk  input  1  the single clock, the fastest system clock (140/170 MHz).
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port mode_req  input  1  requested standard, 0=PAL 1=NTSC; asynchronous to clk.
REQ-007 SHALL have port altern_req  input  1  requested clock plan, 0=140 MHz 1=170 MHz; asynchronous to clk.
REQ-008 SHALL have port phase_inc  output  29  increment driven to the colour-clock phase accumulator.
REQ-009 SHALL have port acc_clr  output  1  one-cycle clear pulse for the phase accumulator.
REQ-010 SHALL have port out_en  output  1  enable for the colorclk4x output gate.
REQ-011 SHALL have port locked  output  1  high when the applied config is stable and output enabled.
REQ-012 SHALL have port busy  output  1  high whenever state is not RUN.
REQ-013 SHALL have port cfg_applied  output  2  {altern, mode} currently loaded.

Function
REQ-014 SHALL pass mode_req and altern_req through a 2-flop synchronizer each; all decisions use synchronized values (sync_cfg = {altern, mode}).
REQ-015 SHALL implement states LOAD, SETTLE, RUN, DEBOUNCE, GATE.
REQ-016 RUN: out_en=1, locked=1; when sync_cfg != cfg_applied, capture candidate=sync_cfg, clear counter, go DEBOUNCE.
REQ-017 DEBOUNCE: outputs unchanged (locked stays 1, busy=1); if sync_cfg == cfg_applied, return RUN with no action; if sync_cfg differs from candidate, recapture candidate and restart count; after STABLE_CYCLES consecutive matching cycles, go GATE.
REQ-018 GATE: out_en=0, locked=0 from first GATE cycle; after GATE_CYCLES cycles go LOAD.
REQ-019 LOAD: exactly one cycle; phase_inc <= table[candidate], cfg_applied <= candidate, acc_clr=1 that cycle only; go SETTLE.
REQ-020 Table: 00 -> 68008027, 01 -> 54907245, 10 -> 56006610, 11 -> 45217732 (index {altern, mode}).
REQ-021 SETTLE: out_en=0, locked=0; input changes ignored; after SETTLE_CYCLES cycles go RUN.
REQ-022 Input changes during GATE/LOAD/SETTLE SHALL be ignored and re-detected on entry to RUN via REQ-016.
REQ-023 phase_inc SHALL change only in LOAD; never while out_en=1.
REQ-024 Counter SHALL be 16 bits, saturating-free; parameters limited to 1..65535 (elaborated check).
REQ-025 acc_clr SHALL never assert in any state other than LOAD.

Reset
REQ-026 On rst: state=LOAD, candidate=00, sync flops=0, counter=0, phase_inc=68008027, cfg_applied=00, acc_clr=0, out_en=0, locked=0, busy=1.
REQ-027 After rst release, first edge executes LOAD (acc_clr pulse), then SETTLE; locked rises after 1+SETTLE_CYCLES cycles.
REQ-028 rst asserted mid-sequence SHALL abort immediately to reset values; no partial increment retained.

Structure
REQ-029 Shared package colorclk_pkg SHALL hold the four 29-bit increment constants, the 2-bit config encoding and the state enumeration.
REQ-030 One sub-module, cdc_sync2 (2-flop synchronizer), instantiated per request bit; FSM and counter inline.

Verification (STABLE=4, GATE=2, SETTLE=3)
REQ-031 Reset release, inputs 00 -> acc_clr high cycle 1, phase_inc=68008027, locked=1 from cycle 5, cfg_applied=00.
REQ-032 mode_req 0->1 held -> after 2 sync + 4 debounce cycles out_en drops for 2 cycles, LOAD pulses acc_clr, phase_inc=54907245, locked after 3 more, cfg_applied=01.
REQ-033 mode_req pulse 1 for 3 cycles then back to 0 -> no GATE, phase_inc unchanged, locked never drops.
REQ-034 altern_req 0->1 during SETTLE -> ignored until RUN, then full sequence; final phase_inc=56006610 (or 45217732 if mode=1).
REQ-035 rst asserted during GATE -> outputs return to REQ-026 values asynchronously; restart sequence as REQ-031.
REQ-036 Request toggling 00->11->10 within DEBOUNCE -> count restarts at each change; only 10 applied, phase_inc=56006610, exactly one acc_clr pulse.
